hamming_sec_scrubber: RTL and testbench

Background scrub controller for an 8-bit-data / 12-bit-codeword Hamming SEC protected memory.
- Periodically walks every address: reads the codeword, computes the syndrome, and writes back the corrected codeword on a single-bit error.
- Counts and reports corrected and uncorrectable events.
- Yields to host traffic. Sits beside the SEC encoder/decoder on the memory's secondary port.

---
 rtl/hamming_sec_scrubber.sv | 234 +++++++++++++++++++++++
 tb/tb_hamming_sec_scrubber.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_sec_scrubber.sv
// Background scrubber for a 12-bit Hamming SEC codeword memory (8 data bits).
// Walks every address, reads each codeword and computes its syndrome. It writes
// back single-bit corrections and counts both corrected and uncorrectable
// words. It only starts a memory access when the host is not using the port.
module hamming_sec_scrubber #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int INTERVAL   = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  host_busy,
  input  logic                  stat_clr,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [11:0]           mem_wdata,
  input  logic [11:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  err_valid,
  output logic                  err_uncorr,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [15:0]           corr_count,
  output logic [15:0]           uncorr_count,
  output logic                  sweep_done
);

  localparam int CW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam logic [CW-1:0]         RELOAD    = CW'(INTERVAL - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_READ  = 3'd2,
    S_CHECK = 3'd3,
    S_WRITE = 3'd4,
    S_NEXT  = 3'd5
  } state_e;

  // Syndrome is the XOR of the Hamming positions (bit index + 1) that are set.
  function automatic logic [3:0] syndrome(input logic [11:0] cw);
    logic [3:0] s;
    s = 4'd0;
    for (int i = 0; i < 12; i++) begin
      if (cw[i]) s = s ^ 4'(i + 1);
      else       s = s;
    end
    return s;
  endfunction

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [11:0]             rdata_q, rdata_d;
  logic [11:0]             wdata_q, wdata_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic                    err_valid_q, err_valid_d;
  logic                    err_uncorr_q, err_uncorr_d;
  logic [ADDR_WIDTH-1:0]   err_addr_q, err_addr_d;
  logic [15:0]             corr_q, corr_d;
  logic [15:0]             uncorr_q, uncorr_d;
  logic                    sweep_q, sweep_d;
  logic [3:0]              syn_s;
  logic                    corr_inc_s, uncorr_inc_s;

  assign syn_s = syndrome(rdata_q);

  // Next-state, access-request and event logic for the scrub sequencer.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    wdata_d      = wdata_q;
    req_d        = req_q;
    we_d         = we_q;
    err_valid_d  = 1'b0;
    err_uncorr_d = err_uncorr_q;
    err_addr_d   = err_addr_q;
    sweep_d      = 1'b0;
    corr_inc_s   = 1'b0;
    uncorr_inc_s = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_WAIT;
          cnt_d   = RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q != CW'(0)) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!host_busy) begin
          state_d = S_READ;
          req_d   = 1'b1;
          we_d    = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_READ: begin
        if (mem_ack) begin
          rdata_d = mem_rdata;
          req_d   = 1'b0;
          state_d = S_CHECK;
        end else begin
          state_d = S_READ;
        end
      end
      S_CHECK: begin
        if (syn_s == 4'd0) begin
          state_d = S_NEXT;
        end else if (syn_s <= 4'd12) begin
          err_valid_d  = 1'b1;
          err_uncorr_d = 1'b0;
          err_addr_d   = addr_q;
          corr_inc_s   = 1'b1;
          wdata_d      = rdata_q ^ 12'(12'd1 << (syn_s - 4'd1));
          state_d      = S_WRITE;
          // Launch the writeback now if the port is free, so WRITE takes one cycle.
          if (!host_busy) begin
            req_d = 1'b1;
            we_d  = 1'b1;
          end else begin
            req_d = 1'b0;
          end
        end else begin
          err_valid_d  = 1'b1;
          err_uncorr_d = 1'b1;
          err_addr_d   = addr_q;
          uncorr_inc_s = 1'b1;
          state_d      = S_NEXT;
        end
      end
      S_WRITE: begin
        if (req_q) begin
          if (mem_ack) begin
            req_d   = 1'b0;
            we_d    = 1'b0;
            state_d = S_NEXT;
          end else begin
            state_d = S_WRITE;
          end
        end else if (!host_busy) begin
          req_d = 1'b1;
          we_d  = 1'b1;
        end else begin
          state_d = S_WRITE;
        end
      end
      S_NEXT: begin
        if (addr_q == LAST_ADDR) begin
          addr_d  = '0;
          sweep_d = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_WIDTH'(1);
        end
        if (enable) begin
          state_d = S_WAIT;
          cnt_d   = RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        we_d    = 1'b0;
      end
    endcase

    // Statistics: clear beats a same-cycle increment; both counters saturate.
    if (stat_clr) begin
      corr_d   = 16'd0;
      uncorr_d = 16'd0;
    end else begin
      corr_d   = (corr_inc_s && corr_q != 16'hFFFF) ? corr_q + 16'd1 : corr_q;
      uncorr_d = (uncorr_inc_s && uncorr_q != 16'hFFFF) ? uncorr_q + 16'd1 : uncorr_q;
    end
  end

  // State and output registers; reset clears everything including the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      rdata_q      <= 12'd0;
      wdata_q      <= 12'd0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      err_valid_q  <= 1'b0;
      err_uncorr_q <= 1'b0;
      err_addr_q   <= '0;
      corr_q       <= 16'd0;
      uncorr_q     <= 16'd0;
      sweep_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      wdata_q      <= wdata_d;
      req_q        <= req_d;
      we_q         <= we_d;
      err_valid_q  <= err_valid_d;
      err_uncorr_q <= err_uncorr_d;
      err_addr_q   <= err_addr_d;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      sweep_q      <= sweep_d;
    end
  end

  assign mem_req      = req_q;
  assign mem_we       = we_q;
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign err_valid    = err_valid_q;
  assign err_uncorr   = err_uncorr_q;
  assign err_addr     = err_addr_q;
  assign corr_count   = corr_q;
  assign uncorr_count = uncorr_q;
  assign sweep_done   = sweep_q;

endmodule

// File: tb/tb_hamming_sec_scrubber.sv
// Directed bench for hamming_sec_scrubber: 4-word memory model with a
// configurable ack delay, and one task per scenario with inline checks.
module tb_hamming_sec_scrubber;

  logic        clk, rst_n, enable, host_busy, stat_clr;
  logic        mem_req, mem_we, mem_ack;
  logic [7:0]  mem_addr, err_addr;
  logic [11:0] mem_wdata, mem_rdata;
  logic        err_valid, err_uncorr, sweep_done;
  logic [15:0] corr_count, uncorr_count;

  int checks = 0;
  int errors = 0;

  // memory model and event logs
  logic [11:0] mem [4];
  int          ack_delay = 0;
  int          wait_cnt = 0;
  int          rd_cnt = 0, wr_cnt = 0, sweep_cnt = 0, err_cnt = 0;
  logic [7:0]  rd_log [16];
  logic [7:0]  last_wr_addr = 8'd0, last_err_addr = 8'd0;
  logic [11:0] last_wr_data = 12'd0;
  logic        last_err_uncorr = 1'b0;
  bit          clr_arm = 0, ack_was_read = 0;

  hamming_sec_scrubber #(.ADDR_WIDTH(8), .DEPTH(4), .INTERVAL(1)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .host_busy(host_busy), .stat_clr(stat_clr),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err_valid(err_valid), .err_uncorr(err_uncorr),
    .err_addr(err_addr), .corr_count(corr_count), .uncorr_count(uncorr_count),
    .sweep_done(sweep_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder and event monitor, acting on falling edges.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = 12'd0;
    stat_clr  = 1'b0;
    forever begin
      @(negedge clk);
      if (sweep_done) sweep_cnt++;
      if (err_valid) begin
        err_cnt++;
        last_err_addr   = err_addr;
        last_err_uncorr = err_uncorr;
      end
      stat_clr = 1'b0;
      if (clr_arm && ack_was_read) begin
        stat_clr = 1'b1;
        clr_arm  = 0;
      end
      ack_was_read = 0;
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            mem[mem_addr[1:0]] = mem_wdata;
            last_wr_addr = mem_addr;
            last_wr_data = mem_wdata;
            wr_cnt++;
          end else begin
            mem_rdata = mem[mem_addr[1:0]];
            if (rd_cnt < 16) rd_log[rd_cnt] = mem_addr;
            rd_cnt++;
            ack_was_read = 1;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic clear_logs();
    rd_cnt = 0; wr_cnt = 0; sweep_cnt = 0; err_cnt = 0;
  endtask

  task automatic run_sweep(output bit ok);
    ok = 0;
    enable = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sweep_done) begin
        ok = 1;
        break;
      end
    end
    enable = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b0; host_busy = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 12'd0;
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, err_valid, err_uncorr, err_addr,
         corr_count, uncorr_count, sweep_done} !== 67'd0) begin
      errors++;
      $display("FAIL reset_outputs: got req=%b we=%b addr=%h wdata=%h ev=%b eu=%b ea=%h cc=%h uc=%h sd=%b required all 0",
               mem_req, mem_we, mem_addr, mem_wdata, err_valid, err_uncorr, err_addr,
               corr_count, uncorr_count, sweep_done);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_clean_sweep();
    bit ok;
    clear_logs();
    run_sweep(ok);
    checks++; if (!ok) begin errors++; $display("FAIL clean_sweep_timeout: got no sweep_done required one"); end
    checks++; if (rd_cnt !== 4) begin errors++; $display("FAIL clean_reads: got %0d required 4", rd_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rd_log[i] !== 8'(i)) begin errors++; $display("FAIL clean_read_addr%0d: got %0d required %0d", i, rd_log[i], i); end
    end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL clean_writes: got %0d required 0", wr_cnt); end
    checks++; if (sweep_cnt !== 1) begin errors++; $display("FAIL clean_sweep_pulses: got %0d required 1", sweep_cnt); end
    checks++; if (mem_addr !== 8'd0) begin errors++; $display("FAIL clean_wrap: got %0d required 0", mem_addr); end
    checks++; if ({corr_count, uncorr_count} !== 32'd0 || err_cnt !== 0) begin
      errors++; $display("FAIL clean_counts: got cc=%0d uc=%0d errs=%0d required 0", corr_count, uncorr_count, err_cnt);
    end
  endtask

  task automatic test_single_error();
    bit ok;
    clear_logs();
    mem[2] = 12'h001;
    run_sweep(ok);
    checks++; if (!ok) begin errors++; $display("FAIL corr_sweep_timeout: got no sweep_done required one"); end
    checks++; if (err_cnt !== 1 || last_err_addr !== 8'd2 || last_err_uncorr !== 1'b0) begin
      errors++; $display("FAIL corr_report: got n=%0d addr=%0d unc=%b required 1/2/0", err_cnt, last_err_addr, last_err_uncorr);
    end
    checks++; if (wr_cnt !== 1 || last_wr_addr !== 8'd2 || last_wr_data !== 12'h000) begin
      errors++; $display("FAIL corr_write: got n=%0d addr=%0d data=%h required 1/2/000", wr_cnt, last_wr_addr, last_wr_data);
    end
    checks++; if (corr_count !== 16'd1) begin errors++; $display("FAIL corr_count: got %0d required 1", corr_count); end
    checks++; if (err_addr !== 8'd2) begin errors++; $display("FAIL corr_err_addr_hold: got %0d required 2", err_addr); end
  endtask

  task automatic test_uncorrectable();
    bit ok;
    clear_logs();
    mem[1] = 12'h090;
    run_sweep(ok);
    checks++; if (!ok) begin errors++; $display("FAIL unc_sweep_timeout: got no sweep_done required one"); end
    checks++; if (err_cnt !== 1 || last_err_addr !== 8'd1 || last_err_uncorr !== 1'b1) begin
      errors++; $display("FAIL unc_report: got n=%0d addr=%0d unc=%b required 1/1/1", err_cnt, last_err_addr, last_err_uncorr);
    end
    checks++; if (wr_cnt !== 0) begin errors++; $display("FAIL unc_no_write: got %0d writes required 0", wr_cnt); end
    checks++; if (uncorr_count !== 16'd1 || corr_count !== 16'd1) begin
      errors++; $display("FAIL unc_counts: got uc=%0d cc=%0d required 1/1", uncorr_count, corr_count);
    end
    mem[1] = 12'h000;
  endtask

  task automatic test_host_busy();
    clear_logs();
    ack_delay = 3;
    host_busy = 1'b1;
    enable = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL busy_hold%0d: got req=%b required 0", i, mem_req); end
    end
    host_busy = 1'b0;
    @(negedge clk);
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 8'd0) begin
      errors++; $display("FAIL busy_release_read: got req=%b we=%b addr=%0d required 1/0/0", mem_req, mem_we, mem_addr);
    end
    host_busy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL busy_mid_read%0d: got req=%b required 1", i, mem_req); end
    end
    host_busy = 1'b0;
    enable = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (rd_cnt !== 1 || mem_addr !== 8'd1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL busy_stop: got reads=%0d addr=%0d req=%b required 1/1/0", rd_cnt, mem_addr, mem_req);
    end
    ack_delay = 0;
  endtask

  task automatic test_saturate_and_clear();
    bit ok;
    clear_logs();
    force dut.corr_q = 16'hFFFF;
    @(negedge clk);
    release dut.corr_q;
    mem[3] = 12'h004;
    run_sweep(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sat_sweep_timeout: got no sweep_done required one"); end
    checks++; if (corr_count !== 16'hFFFF) begin errors++; $display("FAIL sat_count: got %h required ffff", corr_count); end
    checks++; if (mem[3] !== 12'h000 || last_err_addr !== 8'd3) begin
      errors++; $display("FAIL sat_write: got mem3=%h eaddr=%0d required 000/3", mem[3], last_err_addr);
    end
    clear_logs();
    mem[0] = 12'h800;
    clr_arm = 1;
    run_sweep(ok);
    checks++; if (!ok) begin errors++; $display("FAIL clr_sweep_timeout: got no sweep_done required one"); end
    checks++; if (corr_count !== 16'd0 || uncorr_count !== 16'd0) begin
      errors++; $display("FAIL clr_wins: got cc=%h uc=%h required 0/0", corr_count, uncorr_count);
    end
    checks++; if (mem[0] !== 12'h000 || last_err_addr !== 8'd0 || wr_cnt !== 1) begin
      errors++; $display("FAIL clr_pos12_fix: got mem0=%h eaddr=%0d writes=%0d required 000/0/1", mem[0], last_err_addr, wr_cnt);
    end
  endtask

  task automatic test_enable_drop_write();
    bit found;
    clear_logs();
    found = 0;
    mem[2] = 12'h010;
    ack_delay = 3;
    enable = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_req && mem_we) begin
        found = 1;
        break;
      end
    end
    enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (!found) begin errors++; $display("FAIL drop_no_write_seen: got none required a write"); end
    checks++; if (wr_cnt !== 1 || last_wr_addr !== 8'd2 || mem[2] !== 12'h000) begin
      errors++; $display("FAIL drop_write_done: got n=%0d addr=%0d mem2=%h required 1/2/000", wr_cnt, last_wr_addr, mem[2]);
    end
    checks++; if (mem_addr !== 8'd3 || rd_cnt !== 3 || mem_req !== 1'b0) begin
      errors++; $display("FAIL drop_idle: got addr=%0d reads=%0d req=%b required 3/3/0", mem_addr, rd_cnt, mem_req);
    end
    checks++; if (corr_count !== 16'd1) begin errors++; $display("FAIL drop_count: got %0d required 1", corr_count); end
  endtask

  task automatic test_reset_mid_read();
    bit found;
    found = 0;
    ack_delay = 50;
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem_req) begin
        found = 1;
        break;
      end
    end
    checks++; if (!found || mem_addr !== 8'd3) begin
      errors++; $display("FAIL rst_read_start: got found=%0d addr=%0d required 1/3", found, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, err_valid, err_uncorr, err_addr,
         corr_count, uncorr_count, sweep_done} !== 67'd0) begin
      errors++;
      $display("FAIL rst_async_clear: got req=%b addr=%h wdata=%h ea=%h cc=%h uc=%h required all 0",
               mem_req, mem_addr, mem_wdata, err_addr, corr_count, uncorr_count);
    end
    enable = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (mem_req !== 1'b0 || mem_addr !== 8'd0) begin
      errors++; $display("FAIL rst_after: got req=%b addr=%0d required 0/0", mem_req, mem_addr);
    end
    ack_delay = 0;
  endtask

  initial begin
    test_reset();
    test_clean_sweep();
    test_single_error();
    test_uncorrectable();
    test_host_busy();
    test_saturate_and_clear();
    test_enable_drop_write();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
